alarm_timer: RTL and testbench



---
 rtl/alarm_timer_pkg.sv | 16 +
 rtl/alarm_timer_second_prescaler.sv | 32 +++
 rtl/alarm_timer.sv | 91 +++++++++
 tb/tb_alarm_timer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared constants for the alarm timer and the time-parameter store:
// interval select codes and the countdown FSM state encoding.
package alarm_timer_pkg;

  localparam logic [1:0] ARM_DELAY       = 2'b00;
  localparam logic [1:0] DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] ALARM_ON        = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10
  } state_e;

endpackage

// File: rtl/alarm_timer_second_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_DIV enabled cycles.
// A synchronous clear holds the counter at zero so every countdown starts on a full second.
module second_prescaler #(
  parameter int CLK_DIV = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_timer.sv
// Countdown timer: latches an interval code, reads its seconds from the parameter
// store one cycle later, counts them down and pulses expired on completion.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_DIV = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_req,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic       one_hz_enable,
  output logic [3:0] remaining
);

  state_e     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic [3:0] remaining_q, remaining_d;
  logic       expired_q, expired_d;
  logic       tick;

  second_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != COUNT),
    .en    (state_q == COUNT),
    .tick  (tick)
  );

  // A restart takes priority over everything, including an expiring tick.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    if (start_timer) begin
      state_d     = LOAD;
      interval_d  = interval_req;
      remaining_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (value == 4'd0) begin
            state_d   = IDLE;
            expired_d = 1'b1;
          end else begin
            state_d     = COUNT;
            remaining_d = value;
          end
        end
        COUNT: begin
          if (tick) begin
            if (remaining_q <= 4'd1) begin
              state_d     = IDLE;
              remaining_d = '0;
              expired_d   = 1'b1;
            end else begin
              remaining_d = remaining_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      interval_q  <= ARM_DELAY;
      remaining_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
    end
  end

  assign interval      = interval_q;
  assign expired       = expired_q;
  assign remaining     = remaining_q;
  assign busy          = (state_q != IDLE);
  assign one_hz_enable = tick;

endmodule

// File: tb/tb_alarm_timer.sv
// Bench for alarm_timer: constant-expectation table, multi-cycle corner sequences,
// and random traffic checked every cycle against an elapsed-time reference model.
module tb_alarm_timer;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] interval_req = 2'b00;
  logic [3:0] value;
  logic [1:0] interval;
  logic       expired, busy, one_hz_enable;
  logic [3:0] remaining;

  logic [3:0] store [4];
  assign value = store[interval];

  alarm_timer #(.CLK_DIV(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval_req  (interval_req),
    .value         (value),
    .interval      (interval),
    .expired       (expired),
    .busy          (busy),
    .one_hz_enable (one_hz_enable),
    .remaining     (remaining)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: a countdown is described only by its start cycle and captured value.
  bit         m_active = 1'b0;
  int         m_s = 0;
  logic [1:0] m_code = 2'b00;
  int         m_v = 0;
  bit         m_rem_known = 1'b1;

  typedef struct {
    logic [1:0] req;
    logic [3:0] val;
    int         exp_expire;
    int         exp_busy;
    int         exp_ticks;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [8:0] obs();
    return {interval, expired, busy, one_hz_enable, remaining};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs from elapsed cycles since the start pulse:
  // cycle +1 is the lookup cycle, then value*D counting cycles, then the pulse.
  task automatic model_check();
    logic [8:0] e, m;
    int rel, endc;
    e = {m_code, 7'd0};
    m = 9'h1FF;
    if (!m_active) begin
      if (!m_rem_known) m[3:0] = 4'h0;
    end else begin
      rel  = cyc - m_s;
      endc = 2 + m_v * D;
      if (rel == 1) begin
        e[5]    = 1'b1;
        m[3:0]  = 4'h0;
      end else if (rel < endc) begin
        e[5]   = 1'b1;
        e[3:0] = 4'(m_v - (rel - 2) / D);
        e[4]   = ((rel - 2) % D) == (D - 1);
      end else begin
        e[6]     = 1'b1;
        m_active = 1'b0;
        if (m_v == 0) begin
          m[3:0]      = 4'h0;
          m_rem_known = 1'b0;
        end else begin
          m_rem_known = 1'b1;
        end
      end
    end
    check("model", 32'(obs() & m), 32'(e & m));
  endtask

  task automatic cyc_step();
    if (m_active && cyc == m_s + 1) m_v = int'(store[m_code]);
    if (start_timer) begin
      m_active    = 1'b1;
      m_s         = cyc;
      m_code      = interval_req;
      m_rem_known = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
    start_timer = 1'b0;
    model_check();
  endtask

  task automatic run_watch(input int t0, input int n, output int nexp, output int first);
    nexp  = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      cyc_step();
      if (expired) begin
        nexp++;
        if (first < 0) first = cyc - t0;
      end
    end
  endtask

  task automatic store_defaults();
    store[0] = 4'd6;
    store[1] = 4'd8;
    store[2] = 4'd15;
    store[3] = 4'd10;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, first, nexp, nb, nt, rem2, n1, n2, f1, f2;
    bit found;

    tbl[0] = '{2'b00, 4'd6,  26, 25, 6};
    tbl[1] = '{2'b01, 4'd8,  34, 33, 8};
    tbl[2] = '{2'b10, 4'd15, 62, 61, 15};
    tbl[3] = '{2'b11, 4'd10, 42, 41, 10};
    tbl[4] = '{2'b00, 4'd0,  2,  1,  0};
    tbl[5] = '{2'b01, 4'd1,  6,  5,  1};

    store_defaults();
    repeat (2) @(posedge clock);
    #1;
    check("rst_interval",  32'(interval), 32'd0);
    check("rst_expired",   32'(expired), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_one_hz",    32'(one_hz_enable), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      store[tbl[i].req] = tbl[i].val;
      cyc_step();
      cyc_step();
      interval_req = tbl[i].req;
      start_timer  = 1'b1;
      t0 = cyc;
      first = -1; nexp = 0; nb = 0; nt = 0; rem2 = 0;
      for (int k = 1; k <= tbl[i].exp_expire + 4; k++) begin
        cyc_step();
        if (k == 1) check("tbl_interval", 32'(interval), 32'(tbl[i].req));
        if (k == 2) rem2 = int'(remaining);
        if (expired) begin
          nexp++;
          if (first < 0) first = k;
        end
        nb += int'(busy);
        nt += int'(one_hz_enable);
      end
      check("tbl_expire_cycle", 32'(first), 32'(tbl[i].exp_expire));
      check("tbl_pulse_count",  32'(nexp), 32'd1);
      check("tbl_busy_cycles",  32'(nb), 32'(tbl[i].exp_busy));
      check("tbl_ticks",        32'(nt), 32'(tbl[i].exp_ticks));
      if (tbl[i].val != 4'd0) check("tbl_first_remaining", 32'(rem2), 32'(tbl[i].val));
    end
    store_defaults();
    cyc_step();

    // Restart at remaining==3: the first count must never pulse.
    interval_req = 2'b01;
    start_timer  = 1'b1;
    t0 = cyc;
    cyc_step();
    found = 1'b0;
    n1 = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (busy && remaining == 4'd3) found = 1'b1;
      else begin
        cyc_step();
        if (expired) n1++;
      end
    end
    check("restart_reach_rem3", 32'(found), 32'd1);
    interval_req = 2'b10;
    start_timer  = 1'b1;
    t1 = cyc;
    run_watch(t1, 70, n2, f2);
    check("restart_interval",   32'(interval), 32'd2);
    check("restart_pulses",     32'(n1 + n2), 32'd1);
    check("restart_expire_rel", 32'(f2), 32'd62);

    // Store reprogrammed mid-count has no effect.
    interval_req = 2'b11;
    start_timer  = 1'b1;
    t0 = cyc;
    run_watch(t0, 12, n1, f1);
    store[3] = 4'd3;
    run_watch(t0, 34, n2, f2);
    check("reprog_pulses",     32'(n1 + n2), 32'd1);
    check("reprog_expire_rel", 32'(f2), 32'd42);
    store[3] = 4'd10;

    // Restart on the expiring tick suppresses the pulse.
    interval_req = 2'b00;
    start_timer  = 1'b1;
    t0 = cyc;
    run_watch(t0, 25, n1, f1);
    check("coll_on_tick", 32'(one_hz_enable), 32'd1);
    interval_req = 2'b01;
    start_timer  = 1'b1;
    t1 = cyc;
    run_watch(t1, 40, n2, f2);
    check("coll_pulses",     32'(n1 + n2), 32'd1);
    check("coll_expire_rel", 32'(f2), 32'd34);

    // Reset mid-count clears everything at once and loses the pending expiry.
    interval_req = 2'b10;
    start_timer  = 1'b1;
    t0 = cyc;
    run_watch(t0, 20, n1, f1);
    reset = 1'b1;
    #1;
    check("midrst_outputs", 32'(obs()), 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    reset       = 1'b0;
    m_active    = 1'b0;
    m_code      = 2'b00;
    m_rem_known = 1'b1;
    run_watch(t0, 80, n2, f2);
    check("midrst_no_pulse", 32'(n1 + n2), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) store[$urandom_range(0, 3)] = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        interval_req = 2'($urandom_range(0, 3));
        start_timer  = 1'b1;
      end
      cyc_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
